// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// The optional per-domain ack handshake is enabled with RSTSEQ_ACK_EN.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_GAP,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_ACK_TIMEOUT = 16;

    // One extra bit so the index can also express "all released".
    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Saturating up-counter shared by the HOLD, GAP and WAIT_ACK phases.
// hit is high while the count equals the compare value.
module rst_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] cmp,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !hit) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit = (count == cmp);

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream synchronous resets one domain at a time, in ascending order.
// Define RSTSEQ_ACK_EN to wait for a per-domain ready ack after each release.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sw_rst_req,
`ifdef RSTSEQ_ACK_EN
    input  logic [NUM_DOMAINS-1:0]               dom_ready,
    output logic                                 err_timeout,
`endif
    output logic [NUM_DOMAINS-1:0]               rst_out,
    output logic [idx_width(NUM_DOMAINS)-1:0]    rel_idx,
    output logic                                 seq_done
);

    localparam int IDX_W = idx_width(NUM_DOMAINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0] ALL_IDX  = IDX_W'(NUM_DOMAINS);

    // The timer counts from 0 after each state change, so a phase of N
    // edges ends when the count reaches N-1.
    localparam logic [CNT_W-1:0] HOLD_CMP = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_CMP  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_CMP  = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic             tmr_clr;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_cmp;
    logic             hit;
    logic             ack;

`ifdef RSTSEQ_ACK_EN
    // rel_idx has already advanced past the domain we are waiting on.
    always_comb begin
        ack = 1'b0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (IDX_W'(i + 1) == rel_idx) begin
                ack = dom_ready[i];
            end
        end
    end
`else
    assign ack = 1'b0;
`endif

    always_comb begin
        tmr_cmp = '0;
        tmr_en  = 1'b0;
        tmr_clr = 1'b1;
        case (state)
            ST_HOLD: begin
                tmr_cmp = HOLD_CMP;
                tmr_en  = 1'b1;
                tmr_clr = hit;
            end
            ST_GAP: begin
                tmr_cmp = GAP_CMP;
                tmr_en  = 1'b1;
                tmr_clr = hit;
            end
            ST_WAIT_ACK: begin
                tmr_cmp = ACK_CMP;
                tmr_en  = 1'b1;
                tmr_clr = hit || ack;
            end
            default: begin
                tmr_clr = 1'b1;
            end
        endcase
        if (sw_rst_req) begin
            tmr_clr = 1'b1;
        end
    end

    rst_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .cmp (tmr_cmp),
        .hit (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ASSERT;
            rst_out  <= '1;
            rel_idx  <= '0;
            seq_done <= 1'b0;
`ifdef RSTSEQ_ACK_EN
            err_timeout <= 1'b0;
`endif
        end else if (sw_rst_req) begin
            state    <= ST_HOLD;
            rst_out  <= '1;
            rel_idx  <= '0;
            seq_done <= 1'b0;
`ifdef RSTSEQ_ACK_EN
            err_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                ST_ASSERT: begin
                    state <= ST_HOLD;
                end
                ST_HOLD, ST_GAP: begin
                    if (hit) begin
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (IDX_W'(i) == rel_idx) begin
                                rst_out[i] <= 1'b0;
                            end
                        end
                        rel_idx <= rel_idx + IDX_W'(1);
`ifdef RSTSEQ_ACK_EN
                        state <= ST_WAIT_ACK;
`else
                        state <= (rel_idx == LAST_IDX) ? ST_DONE : ST_GAP;
`endif
                    end
                end
                ST_WAIT_ACK: begin
                    // A missing ack is flagged but does not stall the sequence.
                    if (ack || hit) begin
`ifdef RSTSEQ_ACK_EN
                        if (!ack) begin
                            err_timeout <= 1'b1;
                        end
`endif
                        state <= (rel_idx == ALL_IDX) ? ST_DONE : ST_GAP;
                    end
                end
                ST_DONE: begin
                    seq_done <= 1'b1;
                end
                default: begin
                    state <= ST_ASSERT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: default 4-domain instance plus a
// single-domain instance, compared against an arithmetic release-schedule model.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] rst_out;
    logic [2:0] rel_idx;
    logic       seq_done;

    logic       rst1 = 1'b1;
    logic       sw1 = 1'b0;
    logic [0:0] rst_out1;
    logic [0:0] rel_idx1;
    logic       seq_done1;

`ifdef RSTSEQ_ACK_EN
    logic [3:0] dom_ready = 4'b1111;
    logic [0:0] dom_ready1 = 1'b1;
    logic       err_timeout;
    logic       err_timeout1;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: k = edges since the current E0, or -1 while held in reset.
    int         k = -1;
    int         k1 = -1;
    logic [3:0] exp_out;
    logic [2:0] exp_idx;
    logic       exp_done;
    logic [0:0] exp_out1;
    logic [0:0] exp_idx1;
    logic       exp_done1;

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
`ifdef RSTSEQ_ACK_EN
        .dom_ready  (dom_ready),
        .err_timeout(err_timeout),
`endif
        .rst_out    (rst_out),
        .rel_idx    (rel_idx),
        .seq_done   (seq_done)
    );

    reset_sequencer #(
        .NUM_DOMAINS (1),
        .HOLD_CYCLES (1)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst1),
        .sw_rst_req (sw1),
`ifdef RSTSEQ_ACK_EN
        .dom_ready  (dom_ready1),
        .err_timeout(err_timeout1),
`endif
        .rst_out    (rst_out1),
        .rel_idx    (rel_idx1),
        .seq_done   (seq_done1)
    );

    // Number of domains released kk edges after E0.
    function automatic int released(input int kk, input int num, input int hold, input int gap);
        int n;
        if (kk < hold) return 0;
        n = (kk - hold) / gap + 1;
        return (n > num) ? num : n;
    endfunction

    function automatic logic done_at(input int kk, input int num, input int hold, input int gap);
        return (kk >= hold + (num - 1) * gap + 1);
    endfunction

    task automatic tick(input logic r, input logic s);
        int n;
        rst = r;
        sw_rst_req = s;
        @(posedge clk);
        if (r) k = -1;
        else if (s) k = 0;
        else if (k < 0) k = 0;
        else k++;
        n = released(k, 4, 8, 4);
        exp_out  = 4'b1111 << n;
        exp_idx  = 3'(n);
        exp_done = done_at(k, 4, 8, 4);
        #1;
    endtask

    task automatic tick1(input logic r);
        int n;
        rst1 = r;
        @(posedge clk);
        if (r) k1 = -1;
        else if (k1 < 0) k1 = 0;
        else k1++;
        n = released(k1, 1, 1, 4);
        exp_out1  = (n == 0) ? 1'b1 : 1'b0;
        exp_idx1  = 1'(n);
        exp_done1 = done_at(k1, 1, 1, 4);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 1'b0);
            vectors++;
            if ({rst_out, rel_idx, seq_done} !== {4'b1111, 3'd0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL reset: got out=%b idx=%0d done=%b, want out=1111 idx=0 done=0",
                         rst_out, rel_idx, seq_done);
            end
        end
    endtask

    task automatic test_power_up();
        for (int c = 0; c < 24; c++) begin
            tick(1'b0, 1'b0);
            vectors++;
            if ({rst_out, rel_idx, seq_done} !== {exp_out, exp_idx, exp_done}) begin
                miscompares++;
                $display("[TB] FAIL power_up k=%0d: got out=%b idx=%0d done=%b, want out=%b idx=%0d done=%b",
                         k, rst_out, rel_idx, seq_done, exp_out, exp_idx, exp_done);
            end
        end
    endtask

    task automatic test_sw_pulse();
        tick(1'b0, 1'b1);
        vectors++;
        if ({rst_out, seq_done} !== {4'b1111, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL sw_pulse edge: got out=%b done=%b, want out=1111 done=0",
                     rst_out, seq_done);
        end
        for (int c = 0; c < 24; c++) begin
            tick(1'b0, 1'b0);
            vectors++;
            if ({rst_out, rel_idx, seq_done} !== {exp_out, exp_idx, exp_done}) begin
                miscompares++;
                $display("[TB] FAIL sw_pulse k=%0d: got out=%b idx=%0d done=%b, want out=%b idx=%0d done=%b",
                         k, rst_out, rel_idx, seq_done, exp_out, exp_idx, exp_done);
            end
        end
    endtask

    task automatic test_rst_mid();
        tick(1'b1, 1'b0);
        while (k < 13) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        vectors++;
        if ({rst_out, rel_idx, seq_done} !== {4'b1111, 3'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rst_mid edge: got out=%b idx=%0d done=%b, want out=1111 idx=0 done=0",
                     rst_out, rel_idx, seq_done);
        end
        for (int c = 0; c < 24; c++) begin
            tick(1'b0, 1'b0);
            vectors++;
            if ({rst_out, rel_idx, seq_done} !== {exp_out, exp_idx, exp_done}) begin
                miscompares++;
                $display("[TB] FAIL rst_mid k=%0d: got out=%b idx=%0d done=%b, want out=%b idx=%0d done=%b",
                         k, rst_out, rel_idx, seq_done, exp_out, exp_idx, exp_done);
            end
        end
    endtask

    task automatic test_sw_hold();
        int since_last;
        tick(1'b0, 1'b1);
        while (k < 10) tick(1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b1);
            vectors++;
            if (rst_out !== 4'b1111) begin
                miscompares++;
                $display("[TB] FAIL sw_hold held: got out=%b, want out=1111", rst_out);
            end
        end
        since_last = 0;
        for (int c = 0; c < 24; c++) begin
            tick(1'b0, 1'b0);
            since_last++;
            vectors++;
            if ((rst_out[0] !== (since_last < 8)) ||
                ({rst_out, rel_idx, seq_done} !== {exp_out, exp_idx, exp_done})) begin
                miscompares++;
                $display("[TB] FAIL sw_hold edge+%0d: got out=%b idx=%0d done=%b, want out=%b idx=%0d done=%b",
                         since_last, rst_out, rel_idx, seq_done, exp_out, exp_idx, exp_done);
            end
        end
    endtask

    task automatic test_random();
        logic r;
        logic s;
        int   s_hold = 0;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 39) == 0);
            if (s_hold == 0 && $urandom_range(0, 29) == 0) s_hold = $urandom_range(1, 4);
            s = (s_hold > 0);
            if (s_hold > 0) s_hold--;
            tick(r, s);
            vectors++;
            if ({rst_out, rel_idx, seq_done} !== {exp_out, exp_idx, exp_done}) begin
                miscompares++;
                $display("[TB] FAIL random c=%0d rst=%b sw=%b: got out=%b idx=%0d done=%b, want out=%b idx=%0d done=%b",
                         c, r, s, rst_out, rel_idx, seq_done, exp_out, exp_idx, exp_done);
            end
        end
    endtask

    task automatic test_single_domain();
        tick1(1'b1);
        tick1(1'b1);
        vectors++;
        if ({rst_out1, rel_idx1, seq_done1} !== {1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL single reset: got out=%b idx=%0d done=%b, want out=1 idx=0 done=0",
                     rst_out1, rel_idx1, seq_done1);
        end
        for (int c = 0; c < 6; c++) begin
            tick1(1'b0);
            vectors++;
            if ({rst_out1, rel_idx1, seq_done1} !== {exp_out1, exp_idx1, exp_done1}) begin
                miscompares++;
                $display("[TB] FAIL single k=%0d: got out=%b idx=%0d done=%b, want out=%b idx=%0d done=%b",
                         k1, rst_out1, rel_idx1, seq_done1, exp_out1, exp_idx1, exp_done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sw_pulse();
        test_rst_mid();
        test_sw_hold();
        test_random();
        test_single_domain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
